// File: rtl/and_arbiter.sv
// Round-robin arbiter that shares one registered bitwise-AND unit among N_REQ
// requesters. It grants one requester, evaluates a & b, and pulses done.
module and_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic [15:0]            op_count
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      cur_q, cur_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;

  logic               sel_vld;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      idx_n;
  logic [WIDTH-1:0]   opa_sel;
  logic [WIDTH-1:0]   opb_sel;

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Scan upward from last+1 (mod N_REQ); the first requester found wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    idx_n   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_n = IW'((32'(last_q) + k) % N_REQ);
      if (!sel_vld && req[idx_n]) begin
        sel_vld = 1'b1;
        sel_idx = idx_n;
      end
    end
  end

  always_comb begin
    opa_sel = '0;
    opb_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel_idx == IW'(i)) begin
        opa_sel = a_in[i*WIDTH +: WIDTH];
        opb_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    cur_d    = cur_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          gnt_d   = onehot(sel_idx);
          busy_d  = 1'b1;
          cur_d   = sel_idx;
          last_d  = sel_idx;
          opa_d   = opa_sel;
          opb_d   = opb_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        gnt_d    = '0;
        result_d = opa_q & opb_q;
        done_d   = onehot(cur_q);
        cnt_d    = cnt_q + 16'd1;
        state_d  = RESP;
      end
      RESP: begin
        done_d  = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      last_q   <= IW'(N_REQ - 1);
      cur_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign op_count = cnt_q;

endmodule
